// File: rtl/adc_delay_cal_if.sv
// Capture-path calibration bundle: ADC sample stream in, IDELAY control and status out.
// slave = calibration sequencer, master = capture/register environment that drives it.
interface adc_delay_cal_if #(
    parameter int TAP_W  = 5,
    parameter int DATA_W = 14
);
    logic              cal_start;
    logic [DATA_W-1:0] adc_data;
    logic              adc_data_vld;
    logic              delay_rst;
    logic              tap_load;
    logic [TAP_W-1:0]  tap_value;
    logic              data_valid_en;
    logic              cal_busy;
    logic              cal_done;
    logic              cal_fail;
    logic [TAP_W-1:0]  eye_start;
    logic [TAP_W:0]    eye_width;

    modport master (
        output cal_start, adc_data, adc_data_vld,
        input  delay_rst, tap_load, tap_value, data_valid_en,
               cal_busy, cal_done, cal_fail, eye_start, eye_width
    );

    modport slave (
        input  cal_start, adc_data, adc_data_vld,
        output delay_rst, tap_load, tap_value, data_valid_en,
               cal_busy, cal_done, cal_fail, eye_start, eye_width
    );
endinterface

// File: rtl/adc_delay_cal.sv
// IDELAY sweep/centre sequencer: per tap 1 load + SETTLE + window check + 1 eval; status 1 cycle after final load.
// No backpressure: adc_data_vld gaps only stretch the window, bounded by TIMEOUT_CYCLES per tap.
module adc_delay_cal #(
    parameter int                TAP_W          = 5,
    parameter int                DATA_W         = 14,
    parameter logic [DATA_W-1:0] PATTERN_A      = 14'h2AAA,
    parameter int                RST_CYCLES     = 8,
    parameter int                SETTLE_CYCLES  = 16,
    parameter int                WIN_SAMPLES    = 256,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter int                MIN_EYE        = 3
) (
    input  logic            s_axi_aclk,
    input  logic            s_axi_aresetn,
    adc_delay_cal_if.slave  cal
);
    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_CENTER, S_DONE, S_FAIL
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + RST_CYCLES + SETTLE_CYCLES + 1);
    localparam int SMP_W = $clog2(WIN_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_ONE     = SMP_W'(1);
    localparam logic [SMP_W-1:0] WIN_LAST    = SMP_W'(WIN_SAMPLES - 1);
    localparam logic [TAP_W:0]   LEN_ONE     = (TAP_W+1)'(1);
    localparam logic [TAP_W:0]   MIN_LEN     = (TAP_W+1)'(MIN_EYE);
    localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
    localparam logic [TAP_W-1:0] TAP_LAST    = '1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [SMP_W-1:0]  smp_cnt;
    logic [DATA_W-1:0] prev_dat;
    logic              prev_vld, tap_bad;
    logic [TAP_W-1:0]  tap, tap_hold, run_start, best_start, eye_start_q;
    logic [TAP_W:0]    run_len, best_len, eye_width_q;
    logic              busy, done, fail, dven;

    logic              smp_ok, win_end, tmo, eye_ok;
    logic [TAP_W-1:0]  center_tap, run_start_nxt;
    logic [TAP_W:0]    run_len_nxt;

    always_comb begin
        smp_ok  = (cal.adc_data == PATTERN_A || cal.adc_data == ~PATTERN_A)
                  && (!prev_vld || cal.adc_data == ~prev_dat);
        win_end = cal.adc_data_vld && (smp_cnt == WIN_LAST);
        tmo     = (cnt == TMO_LAST);
        eye_ok  = (best_len >= MIN_LEN);
        // Sum is formed one bit wider, but an eye never extends past the last tap so the centre fits.
        center_tap = eye_ok ? TAP_W'({1'b0, best_start} + ((best_len - LEN_ONE) >> 1)) : '0;
        if (tap_bad) begin
            run_len_nxt   = '0;
            run_start_nxt = run_start;
        end else begin
            run_len_nxt   = run_len + LEN_ONE;
            run_start_nxt = (run_len == '0) ? tap : run_start;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state <= S_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (cal.cal_start)     state_nxt = S_RST;
            S_RST:    if (cnt == RST_LAST)    state_nxt = S_LOAD;
            S_LOAD:                           state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_CHECK;
            S_CHECK:  if (win_end || tmo)     state_nxt = S_EVAL;
            S_EVAL:   state_nxt = (tap == TAP_LAST) ? S_CENTER : S_LOAD;
            S_CENTER: state_nxt = eye_ok ? S_DONE : S_FAIL;
            S_DONE:   state_nxt = S_IDLE;
            S_FAIL:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cal.delay_rst = (state == S_RST);
        cal.tap_load  = (state == S_LOAD) || (state == S_CENTER);
        cal.tap_value = tap_hold;
        if (state == S_LOAD)        cal.tap_value = tap;
        else if (state == S_CENTER) cal.tap_value = center_tap;
    end

    assign cal.cal_busy      = busy;
    assign cal.cal_done      = done;
    assign cal.cal_fail      = fail;
    assign cal.data_valid_en = dven;
    assign cal.eye_start     = eye_start_q;
    assign cal.eye_width     = eye_width_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            cnt         <= '0;
            smp_cnt     <= '0;
            prev_dat    <= '0;
            prev_vld    <= 1'b0;
            tap_bad     <= 1'b0;
            tap         <= '0;
            tap_hold    <= '0;
            run_start   <= '0;
            run_len     <= '0;
            best_start  <= '0;
            best_len    <= '0;
            eye_start_q <= '0;
            eye_width_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            dven        <= 1'b0;
        end else begin
            cnt <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + CNT_ONE;
            unique case (state)
                S_IDLE: if (cal.cal_start) begin
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    fail       <= 1'b0;
                    dven       <= 1'b0;
                    tap        <= '0;
                    run_start  <= '0;
                    run_len    <= '0;
                    best_start <= '0;
                    best_len   <= '0;
                end
                S_LOAD: tap_hold <= tap;
                S_SETTLE: begin
                    smp_cnt  <= '0;
                    prev_vld <= 1'b0;
                    tap_bad  <= 1'b0;
                end
                S_CHECK: begin
                    // The alternation reference survives vld gaps; only the window start clears it.
                    if (cal.adc_data_vld) begin
                        smp_cnt  <= smp_cnt + SMP_ONE;
                        prev_dat <= cal.adc_data;
                        prev_vld <= 1'b1;
                        if (!smp_ok) tap_bad <= 1'b1;
                    end
                    if (tmo && !win_end) tap_bad <= 1'b1;
                end
                S_EVAL: begin
                    run_len   <= run_len_nxt;
                    run_start <= run_start_nxt;
                    if (run_len_nxt > best_len) begin
                        best_len   <= run_len_nxt;
                        best_start <= run_start_nxt;
                    end
                    if (tap != TAP_LAST) tap <= tap + TAP_ONE;
                end
                S_CENTER: begin
                    tap_hold    <= center_tap;
                    busy        <= 1'b0;
                    done        <= eye_ok;
                    fail        <= !eye_ok;
                    dven        <= eye_ok;
                    eye_start_q <= best_start;
                    eye_width_q <= best_len;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_delay_cal.sv
// Randomized-data sweep bench: per-tap pass masks drive a checkerboard source, results compared with a longest-eye model.
module tb_adc_delay_cal;
    localparam int NTAP = 32;
    localparam int RST_C = 8;
    localparam int SETTLE_C = 16;
    localparam int WIN_C = 256;
    localparam int TMO_C = 1024;
    localparam logic [13:0] PAT = 14'h2AAA;
    localparam int GLITCH_OFF = 60;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    logic [31:0] pass_m = '0;
    logic [31:0] glitch_m = '0;
    bit          gaps = 0;
    bit          vld_off = 0;

    int         busy_cyc, drst_run, drst_last, load_after_rst, tv_glitch, both;
    logic [4:0] loads[$];
    logic [4:0] prev_tv;
    logic       prev_drst;

    adc_delay_cal_if #(.TAP_W(5), .DATA_W(14)) cal ();

    adc_delay_cal dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cal           (cal)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Checkerboard source: good taps alternate on valid samples, failing taps send noise.
    initial begin
        logic [4:0]  cur_tap;
        logic [13:0] d, last_v;
        bit          v, phase;
        int          off;
        cur_tap = '0; last_v = PAT; phase = 0; off = 0;
        cal.adc_data = '0;
        cal.adc_data_vld = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (cal.tap_load) begin cur_tap = cal.tap_value; off = 0; end
            else off++;
            v = vld_off ? 1'b0 : (gaps ? ($urandom_range(0, 7) != 0) : 1'b1);
            d = cal.adc_data;
            if (pass_m[cur_tap] && glitch_m[cur_tap] && off == GLITCH_OFF) begin
                v = 1'b1;
                d = last_v;
            end else if (v) begin
                if (pass_m[cur_tap]) begin
                    d = phase ? ~PAT : PAT;
                    phase = ~phase;
                end else begin
                    d = 14'($urandom);
                end
            end
            if (v) last_v = d;
            cal.adc_data_vld = v;
            cal.adc_data = d;
        end
    end

    initial begin
        prev_tv = '0; prev_drst = 0;
        forever begin
            @(negedge clk);
            if (cal.cal_busy) busy_cyc++;
            if (cal.delay_rst) drst_run++;
            else if (prev_drst) begin drst_last = drst_run; drst_run = 0; end
            if (cal.tap_load) begin
                loads.push_back(cal.tap_value);
                if (prev_drst) load_after_rst++;
            end
            if (rst_n && !cal.tap_load && cal.tap_value !== prev_tv) tv_glitch++;
            if (cal.cal_done && cal.cal_fail) both++;
            prev_tv = cal.tap_value;
            prev_drst = cal.delay_rst;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, cal.delay_rst, cal.tap_load, cal.tap_value, cal.data_valid_en,
                cal.cal_busy, cal.cal_done, cal.cal_fail, cal.eye_start, cal.eye_width};
    endfunction

    // Longest contiguous run of passing taps; on equal length the lower-tap run wins.
    function automatic void best_eye(input logic [31:0] p, output int bs, output int bl);
        int len;
        bs = 0; bl = 0;
        for (int s = 0; s < NTAP; s++) begin
            if (p[s] && (s == 0 ? 1'b1 : !p[s-1])) begin
                len = 0;
                while (s + len < NTAP && p[s+len]) len++;
                if (len > bl) begin bl = len; bs = s; end
            end
        end
    endfunction

    task automatic clear_mon();
        busy_cyc = 0; drst_run = 0; drst_last = 0; load_after_rst = 0;
        tv_glitch = 0; both = 0;
        loads.delete();
    endtask

    task automatic run_sweep(input string nm, input logic [31:0] pm, input logic [31:0] gm,
                             input bit g, input bit vo, input bit poke, input int exp_busy);
        int bs, bl, exp_tap, seq_bad, cyc;
        bit ok;
        pass_m = pm; glitch_m = gm; gaps = g; vld_off = vo;
        clear_mon();
        cal.cal_start = 1'b1;
        @(posedge clk); #1;
        cal.cal_start = 1'b0;
        chk({nm, "_start"}, {29'd0, cal.cal_busy, cal.delay_rst, cal.data_valid_en}, 32'b110);
        cyc = 0;
        while (cal.cal_busy && cyc < 40000) begin
            cal.cal_start = poke && (cyc == 100 || cyc == 4000);
            @(posedge clk); #1;
            cyc++;
        end
        cal.cal_start = 1'b0;
        chk({nm, "_finished"}, {31'd0, cal.cal_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        best_eye(pm & ~gm, bs, bl);
        ok = (bl >= 3);
        exp_tap = ok ? bs + (bl - 1) / 2 : 0;
        seq_bad = 0;
        for (int k = 0; k < NTAP && k < loads.size(); k++)
            if (loads[k] !== 5'(k)) seq_bad++;
        chk({nm, "_done"}, {31'd0, cal.cal_done}, {31'd0, ok});
        chk({nm, "_fail"}, {31'd0, cal.cal_fail}, {31'd0, !ok});
        chk({nm, "_dven"}, {31'd0, cal.data_valid_en}, {31'd0, ok});
        chk({nm, "_eye_start"}, {27'd0, cal.eye_start}, 32'(bs));
        chk({nm, "_eye_width"}, {26'd0, cal.eye_width}, 32'(bl));
        chk({nm, "_tap_value"}, {27'd0, cal.tap_value}, 32'(exp_tap));
        chk({nm, "_load_count"}, 32'(loads.size()), 32'(NTAP + 1));
        chk({nm, "_last_load"}, (loads.size() > 0) ? {27'd0, loads[$]} : 32'hffff_ffff, 32'(exp_tap));
        chk({nm, "_load_seq"}, 32'(seq_bad), 32'd0);
        chk({nm, "_drst_width"}, 32'(drst_last), 32'(RST_C));
        chk({nm, "_load_after_rst"}, 32'(load_after_rst), 32'd1);
        chk({nm, "_tv_stable"}, 32'(tv_glitch), 32'd0);
        chk({nm, "_flags_excl"}, 32'(both), 32'd0);
        if (exp_busy != 0) chk({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        cal.cal_start = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep("eye8_20", 32'h001F_FF00, 32'd0, 0, 0, 1, RST_C + NTAP * (2 + SETTLE_C + WIN_C) + 1);
        run_sweep("tie", 32'h0000_3C3C, 32'd0, 1, 0, 0, 0);

        // Abort in CHECK of tap 17, then a clean sweep must restart at tap 0.
        pass_m = 32'hFE00_0000; glitch_m = '0; gaps = 0; vld_off = 0;
        clear_mon();
        cal.cal_start = 1'b1;
        @(posedge clk); #1;
        cal.cal_start = 1'b0;
        cyc = 0;
        while (loads.size() < 18 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reached_tap17", 32'(loads.size()), 32'd18);
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", outs(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep("top_eye", 32'hFE00_0000, 32'd0, 0, 0, 0, 0);
        run_sweep("narrow", 32'h0000_0030, 32'd0, 0, 0, 0, 0);
        run_sweep("no_vld", 32'd0, 32'd0, 0, 1, 0, RST_C + NTAP * (2 + SETTLE_C + TMO_C) + 1);
        run_sweep("split", 32'h0000_FFC0, 32'h0000_0200, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_delay_cal.md
# adc_delay_cal

Input-delay calibration sequencer for the AD9643 capture path. With the ADC in alternating-checkerboard test mode, it resets the IDELAY chain, sweeps every tap, and checks a window of samples at each tap. It then loads the tap at the centre of the longest passing eye. It owns `delay_rst` and `data_valid_en` for the capture datapath and reports status to the AXI-Lite register bank.

## Interface
Parameters:
- `TAP_W`, 5: tap width; taps 0..2^TAP_W-1, no wrap.
- `DATA_W`, 14: ADC sample width.
- `PATTERN_A`, 14'h2AAA: checkerboard word A; word B = ~A.
- `RST_CYCLES`, 8: `delay_rst` high time.
- `SETTLE_CYCLES`, 16: wait after each tap load.
- `WIN_SAMPLES`, 256: valid samples checked per tap.
- `TIMEOUT_CYCLES`, 1024: max cycles in CHECK per tap.
- `MIN_EYE`, 3: minimum passing run length for success.

Ports:
- `s_axi_aclk`, in, 1: clock; all logic on rising edge.
- `s_axi_aresetn`, in, 1: asynchronous active-low reset.
- `cal_start`, in, 1: start request, sampled in IDLE only.
- `adc_data`, in, DATA_W: sample, already in the `s_axi_aclk` domain.
- `adc_data_vld`, in, 1: `adc_data` valid this cycle.
- `delay_rst`, out, 1: IDELAY/IDELAYCTRL reset.
- `tap_load`, out, 1: one-cycle load strobe.
- `tap_value`, out, TAP_W: tap to load, held between loads.
- `data_valid_en`, out, 1: capture gate to the downstream datapath.
- `cal_busy`, out, 1: calibration in progress.
- `cal_done`, out, 1: sticky success flag.
- `cal_fail`, out, 1: sticky failure flag.
- `eye_start`, out, TAP_W: first tap of the chosen eye.
- `eye_width`, out, TAP_W+1: length of the chosen eye.

## Operation
- Reset values: all outputs 0. `data_valid_en` stays 0 until the first successful calibration.
- States are IDLE, RST, LOAD, SETTLE, CHECK, EVAL, CENTER, DONE and FAIL.
- **IDLE**
  - `cal_start`=1: go to RST; set `cal_busy`; clear `cal_done`, `cal_fail` and `data_valid_en`; zero the tap and the eye trackers.
- **RST**: hold `delay_rst`=1 for RST_CYCLES cycles, then go to LOAD.
- **LOAD**: pulse `tap_load` for 1 cycle with `tap_value` = current tap, then go to SETTLE.
- **SETTLE**: wait SETTLE_CYCLES cycles; `adc_data` is ignored. Then go to CHECK.
- **CHECK**: count valid samples to WIN_SAMPLES.
  - Each valid sample must equal PATTERN_A or ~PATTERN_A.
  - Every valid sample after the first in the window must also equal ~(previous valid sample).
  - Any violation marks the tap failed. Counting continues to the end of the window.
  - If TIMEOUT_CYCLES cycles elapse before the window completes, the tap is failed.
- **EVAL**: update the run trackers.
  - On pass: if `run_len`=0 then `run_start`=tap; `run_len`++.
  - On fail: `run_len`=0.
  - After the update, if `run_len` > `best_len`, copy the run into best. Strictly greater, so ties keep the earlier eye.
  - Last tap (all ones) goes to CENTER; otherwise tap++ and go to LOAD.
- **CENTER**
  - If `best_len` ≥ MIN_EYE: tap = `best_start` + ((`best_len`−1)>>1), computed at TAP_W+1 bits; the result never exceeds the last tap. Pulse `tap_load`, go to DONE.
  - Otherwise: tap = 0, pulse `tap_load`, go to FAIL.
- **DONE**: `cal_done`=1, `data_valid_en`=1, `cal_busy`=0; latch `eye_start`/`eye_width`; return to IDLE.
- **FAIL**: `cal_fail`=1, `data_valid_en`=0, `cal_busy`=0; `eye_start`/`eye_width` = best found (possibly 0); return to IDLE.
- `cal_start` outside IDLE is ignored; no queuing.
- `adc_data_vld` gaps in CHECK pause counting only. A gap does not reset the previous-sample reference.
- Reset asserted mid-calibration: immediate return to reset values. No `tap_load` is issued on reset.

## Timing
- Start on edge N.
  - Edge N+1: `cal_busy`=1, `delay_rst`=1, `data_valid_en`=0.
  - `delay_rst` falls after exactly RST_CYCLES cycles.
  - First `tap_load` (tap 0) in the following cycle.
- Per tap: 1 (LOAD) + SETTLE_CYCLES + CHECK duration + 1 (EVAL).
- `tap_value` changes only in the cycle `tap_load` is high.
- Final `tap_load` comes 1 cycle after the last EVAL.
- `cal_done`/`cal_fail` and the `cal_busy` fall occur 1 cycle after the final `tap_load`.
- `eye_start`/`eye_width` update in that same cycle.
- `cal_done` and `cal_fail` are never both 1.

## Test plan
- TAP_W=5; pattern passes at taps 8..20 only → `eye_start`=8, `eye_width`=13, final `tap_value`=14, `cal_done`=1, `data_valid_en`=1.
- Passing taps 2..5 and 10..13 (tie, width 4) → `eye_start`=2, final tap 3. Taps 25..31 pass → width 7, final tap 28, no wrap to 0.
- Pass only at taps 4,5 (width 2 < MIN_EYE) → `cal_fail`=1, final `tap_value`=0, `data_valid_en`=0, `eye_width`=2.
- `adc_data_vld` held 0 → every tap times out after 1024 cycles → `cal_fail`=1. A single non-alternating sample at tap 9 inside eye 6..15 splits it → best 10..15, final tap 12.
- `cal_start` pulsed while busy → no restart, sweep duration unchanged. `delay_rst` width exactly 8 cycles; `tap_load` pulses = 33 per run.
- `s_axi_aresetn` low during CHECK of tap 17 → all outputs 0 immediately. A new `cal_start` after release performs a full sweep from tap 0.
